// File: rtl/key_filter_multi.sv
// key_filter_multi: per-channel key synchroniser, debounce FSM and press/release/long-press pulses.
// Define KEY_LONG_EN to compile in the long-press hold counter and key_long.
module key_filter_multi #(
    parameter int KEY_NUM  = 4,
    parameter int CNT_MAX  = 1_000_000,
    parameter int LONG_MAX = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_long
);
`ifdef KEY_LONG_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif
    localparam int CW = (LONG_EN && $clog2(LONG_MAX) > $clog2(CNT_MAX)) ? $clog2(LONG_MAX) : $clog2(CNT_MAX);
    localparam logic [CW-1:0] C_LAST = CW'(CNT_MAX - 1);
    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        FILTER0 = 4'b0010,
        DOWN    = 4'b0100,
        FILTER1 = 4'b1000
    } state_t;
    // High once the synchronisers hold real samples rather than reset values.
    logic live;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            live <= 1'b0;
        else
            live <= 1'b1;
    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        logic r1, r2, arm, nedge, pedge, edge_any, expire;
        logic press_d, release_d, press_q, release_q, held_q;
        logic [CW-1:0] cnt, cnt_d, cnt_n;
        state_t state, state_d;
        // A key held through reset must be seen released before its falling edge counts.
        assign nedge    = !r1 && r2 && arm;
        assign pedge    = r1 && !r2;
        assign edge_any = nedge || pedge;
        assign expire   = cnt == C_LAST;
        always_comb begin
            state_d   = state;
            cnt_d     = '0;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state)
                IDLE:    state_d = nedge ? FILTER0 : IDLE;
                FILTER0: begin
                    state_d = edge_any ? IDLE : expire ? DOWN : FILTER0;
                    press_d = !edge_any && expire;
                    cnt_d   = (edge_any || expire) ? '0 : cnt + 1'b1;
                end
                DOWN:    state_d = pedge ? FILTER1 : DOWN;
                FILTER1: begin
                    state_d   = edge_any ? DOWN : expire ? IDLE : FILTER1;
                    release_d = !edge_any && expire;
                    cnt_d     = (edge_any || expire) ? '0 : cnt + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                r1        <= 1'b1;
                r2        <= 1'b1;
                arm       <= 1'b0;
                state     <= IDLE;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                held_q    <= 1'b0;
            end else begin
                r1        <= key_in[i];
                r2        <= r1;
                arm       <= arm || (live && r1);
                state     <= state_d;
                cnt       <= cnt_n;
                press_q   <= press_d;
                release_q <= release_d;
                held_q    <= state_d == DOWN || state_d == FILTER1;
            end
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_state[i]   = held_q;
`ifdef KEY_LONG_EN
        localparam logic [CW-1:0] L_LAST = CW'(LONG_MAX - 1);
        logic hold, long_hit, done, long_q;
        // Hold count saturates at L_LAST; done blocks a repeat until the key is released.
        assign hold     = state == DOWN && !pedge;
        assign long_hit = hold && cnt == L_LAST;
        assign cnt_n    = hold ? (long_hit ? cnt : cnt + 1'b1) : cnt_d;
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                done   <= 1'b0;
                long_q <= 1'b0;
            end else begin
                done   <= (state_d == DOWN || state_d == FILTER1) && (done || long_hit);
                long_q <= long_hit && !done;
            end
        assign key_long[i] = long_q;
`else
        assign cnt_n       = cnt_d;
        assign key_long[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_key_filter_multi.sv
// tb_key_filter_multi: directed test-plan steps plus random key activity, checked each cycle
// against a run-length model of the debounce rules.
module tb_key_filter_multi;
    localparam int N  = 4;
    localparam int CM = 10;
    localparam int LM = 30;
`ifdef KEY_LONG_EN
    localparam int LONG_ON = 1;
`else
    localparam int LONG_ON = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] key_in = '1;
    logic [N-1:0] key_press, key_release, key_state, key_long;
    int n_assert = 0;
    int n_fail   = 0;
    // Model state: consecutive low/high samples, debounced level, long-press target run.
    int lo_run[N], hi_run[N], tgt[N];
    bit st[N], seen_hi[N], ldone[N];
    int cnt_press[N], cnt_rel[N], cnt_long[N];
    int hold_len[N];
    int p0, r0, l0, s;

    key_filter_multi #(.KEY_NUM(N), .CNT_MAX(CM), .LONG_MAX(LM)) dut (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .key_press(key_press),
        .key_release(key_release),
        .key_state(key_state),
        .key_long(key_long)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: events come from samples up to the previous edge, then this edge's sample is logged.
    task automatic tick();
        logic [N-1:0] ep, er, el, es;
        @(posedge clk);
        #1;
        ep = '0;
        er = '0;
        el = '0;
        es = '0;
        for (int c = 0; c < N; c++) begin
            if (!rst) begin
                st[c]      = 1'b0;
                lo_run[c]  = 0;
                hi_run[c]  = 0;
                seen_hi[c] = 1'b0;
                ldone[c]   = 1'b0;
                tgt[c]     = 0;
            end else begin
                if (!st[c] && seen_hi[c] && lo_run[c] == CM + 1) begin
                    ep[c]    = 1'b1;
                    st[c]    = 1'b1;
                    tgt[c]   = CM + 1 + LM;
                    ldone[c] = 1'b0;
                end else if (st[c] && hi_run[c] == CM + 1) begin
                    er[c] = 1'b1;
                    st[c] = 1'b0;
                end
                if (LONG_ON == 1 && st[c] && !ldone[c] && lo_run[c] == tgt[c]) begin
                    el[c]    = 1'b1;
                    ldone[c] = 1'b1;
                end
                if (key_in[c]) begin
                    hi_run[c]++;
                    lo_run[c]  = 0;
                    seen_hi[c] = 1'b1;
                    if (st[c]) tgt[c] = LM + 1;
                end else begin
                    lo_run[c]++;
                    hi_run[c] = 0;
                end
            end
            es[c] = st[c];
        end
        check("press", 32'(key_press), 32'(ep));
        check("release", 32'(key_release), 32'(er));
        check("state", 32'(key_state), 32'(es));
        check("long", 32'(key_long), 32'(el));
        for (int c = 0; c < N; c++) begin
            cnt_press[c] += int'(key_press[c]);
            cnt_rel[c]   += int'(key_release[c]);
            cnt_long[c]  += int'(key_long[c]);
        end
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            cnt_press[c] = 0;
            cnt_rel[c]   = 0;
            cnt_long[c]  = 0;
            hold_len[c]  = 0;
        end
        // Reset, then a quiet period with all keys released.
        repeat (5) tick();
        check("rst_outputs", 32'({key_press, key_release, key_state, key_long}), 32'h0);
        rst = 1'b1;
        repeat (50) tick();
        s = 0;
        for (int c = 0; c < N; c++) s += cnt_press[c] + cnt_rel[c] + cnt_long[c];
        check("rst_quiet", 32'(s), 32'd0);
        // Clean press and release on ch0.
        key_in[0] = 1'b0;
        tick();
        repeat (10) tick();
        check("press_before_e11", 32'(key_press), 32'h0);
        tick();
        check("press_e11", 32'(key_press), 32'h1);
        check("state_e11", 32'(key_state), 32'h1);
        tick();
        check("press_one_cycle", 32'(key_press), 32'h0);
        repeat (39) tick();
        r0 = cnt_rel[0];
        key_in[0] = 1'b1;
        tick();
        repeat (10) tick();
        check("state_before_rel", 32'(key_state), 32'h1);
        tick();
        check("release_e11", 32'(key_release), 32'h1);
        check("state_after_rel", 32'(key_state), 32'h0);
        repeat (20) tick();
        check("release_once", 32'(cnt_rel[0] - r0), 32'd1);
        // Bouncing ch1: five toggles four cycles apart, ending low.
        p0 = cnt_press[1];
        r0 = cnt_rel[1];
        for (int t = 0; t < 4; t++) begin
            key_in[1] = ~key_in[1];
            repeat (4) tick();
        end
        key_in[1] = 1'b0;
        tick();
        repeat (10) tick();
        check("bounce_no_early_press", 32'(cnt_press[1] - p0), 32'd0);
        tick();
        check("bounce_press_e11", 32'(key_press), 32'h2);
        repeat (10) tick();
        check("bounce_one_press", 32'(cnt_press[1] - p0), 32'd1);
        check("bounce_no_release", 32'(cnt_rel[1] - r0), 32'd0);
        key_in[1] = 1'b1;
        repeat (20) tick();
        // Simultaneous press on ch2 and ch3.
        key_in = 4'h3;
        tick();
        repeat (10) tick();
        tick();
        check("simul_press", 32'(key_press), 32'hC);
        key_in = 4'hF;
        repeat (20) tick();
        // Long press on ch0, held 60 cycles after key_press.
        key_in = 4'hE;
        tick();
        repeat (10) tick();
        tick();
        check("long_run_press", 32'(key_press), 32'h1);
        l0 = cnt_long[0];
        repeat (29) tick();
        check("long_not_early", 32'(key_long), 32'h0);
        tick();
        check("long_p30", 32'(key_long), 32'(LONG_ON));
        repeat (30) tick();
        check("long_once", 32'(cnt_long[0] - l0), 32'(LONG_ON));
        key_in = 4'hF;
        repeat (20) tick();
        // Released 20 cycles after key_press: no long pulse.
        key_in = 4'hE;
        tick();
        repeat (10) tick();
        tick();
        check("short_run_press", 32'(key_press), 32'h1);
        l0 = cnt_long[0];
        repeat (20) tick();
        key_in = 4'hF;
        repeat (40) tick();
        check("short_no_long", 32'(cnt_long[0] - l0), 32'd0);
        // Reset while ch0 is held down.
        key_in = 4'hE;
        tick();
        repeat (10) tick();
        tick();
        repeat (3) tick();
        check("held_before_rst", 32'(key_state), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_state_clear", 32'(key_state), 32'h0);
        repeat (3) tick();
        rst = 1'b1;
        p0 = cnt_press[0];
        repeat (30) tick();
        check("held_after_rst_no_press", 32'(cnt_press[0] - p0), 32'd0);
        key_in[0] = 1'b1;
        repeat (3) tick();
        key_in[0] = 1'b0;
        tick();
        repeat (10) tick();
        tick();
        check("fresh_press_after_rst", 32'(key_press), 32'h1);
        check("fresh_press_count", 32'(cnt_press[0] - p0), 32'd1);
        key_in = 4'hF;
        repeat (20) tick();
        // Random per-channel activity with hold times spanning bounce, press and long press.
        repeat (2500) begin
            for (int c = 0; c < N; c++) begin
                if (hold_len[c] == 0) begin
                    key_in[c]   = ~key_in[c];
                    hold_len[c] = $urandom_range(1, 50);
                end else begin
                    hold_len[c]--;
                end
            end
            tick();
        end
        key_in = 4'hF;
        repeat (30) tick();
        check("final_released", 32'(key_state), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
